// File: rtl/cm_sketch_pkg.sv
// ============================================================================
// Module      : cm_sketch_pkg
// Description : Shared types and helpers for count-min sketch counter rows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cm_sketch_pkg;

    localparam logic [1:0] c_st_clear = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_drain = 2'd2;

    typedef enum logic [1:0] {
        CLEAR = c_st_clear,
        RUN   = c_st_run,
        DRAIN = c_st_drain
    } state_e;

    // Counters of any width up to 64 bits: callers zero-extend in and truncate out.
    function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                            input logic [63:0] max_value);
        return (value >= max_value) ? max_value : value + 64'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/cm_sketch_counter_ram.sv
// ============================================================================
// Module      : cm_sketch_counter_ram
// Description : Simple dual-port counter storage, one write and one registered
//               read port; read-during-write returns the old contents.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cm_sketch_counter_ram #(
    parameter int DEPTH  = 4096,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
        r_rd_data <= r_mem[i_rd_addr];
    end

    assign o_rd_data = r_rd_data;

endmodule

`default_nettype wire

// File: rtl/cm_sketch_row_counter.sv
// ============================================================================
// Module      : cm_sketch_row_counter
// Description : One count-min sketch row: saturating RMW bucket increments with
//               write forwarding, point queries and a full-row clear.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cm_sketch_row_counter
    import cm_sketch_pkg::*;
#(
    parameter int W         = 4096,
    parameter int HASH_SIZE = $clog2(W),
    parameter int CNT_SIZE  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 upd_valid,
    output logic                 upd_ready,
    input  logic [HASH_SIZE-1:0] upd_hash,
    input  logic                 qry_valid,
    output logic                 qry_ready,
    input  logic [HASH_SIZE-1:0] qry_hash,
    output logic                 rsp_valid,
    output logic [CNT_SIZE-1:0]  rsp_count,
    input  logic                 clr_start,
    output logic                 clr_busy
);

    localparam logic [HASH_SIZE-1:0] c_last_addr = HASH_SIZE'(W - 1);
    localparam logic [63:0]          c_cnt_max   = 64'({CNT_SIZE{1'b1}});

    state_e                r_state;
    state_e                w_state_next;
    logic [HASH_SIZE-1:0]  r_clr_addr;

    logic                  r_s1_valid;
    logic [HASH_SIZE-1:0]  r_s1_addr;
    logic                  r_q1_valid;
    logic [HASH_SIZE-1:0]  r_q1_addr;

    logic                  r_fwd_valid;
    logic [HASH_SIZE-1:0]  r_fwd_addr;
    logic [CNT_SIZE-1:0]   r_fwd_data;

    logic                  r_rsp_valid;
    logic [CNT_SIZE-1:0]   r_rsp_count;

    logic                  w_upd_ready;
    logic                  w_qry_ready;
    logic                  w_clr_busy;
    logic                  w_upd_fire;
    logic                  w_qry_fire;
    logic [HASH_SIZE-1:0]  w_rd_addr;
    logic [CNT_SIZE-1:0]   w_rd_data;
    logic                  w_wr_en;
    logic [HASH_SIZE-1:0]  w_wr_addr;
    logic [CNT_SIZE-1:0]   w_wr_data;
    logic [CNT_SIZE-1:0]   w_base;
    logic [CNT_SIZE-1:0]   w_upd_new;
    logic [CNT_SIZE-1:0]   w_qry_data;

    always_comb begin
        w_state_next = r_state;
        w_upd_ready  = 1'b0;
        w_qry_ready  = 1'b0;
        w_clr_busy   = 1'b1;
        case (r_state)
            CLEAR: begin
                if (r_clr_addr == c_last_addr) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_upd_ready = 1'b1;
                w_qry_ready = !upd_valid;
                w_clr_busy  = 1'b0;
                if (clr_start) begin
                    w_state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!r_s1_valid && !r_q1_valid) begin
                    w_state_next = CLEAR;
                end
            end
            default: begin
                w_state_next = CLEAR;
            end
        endcase
    end

    assign w_upd_fire = upd_valid && w_upd_ready;
    assign w_qry_fire = qry_valid && w_qry_ready;
    assign w_rd_addr  = w_upd_fire ? upd_hash : qry_hash;

    // RAM misses the write made in the same cycle as the read; take it from r_fwd_*.
    assign w_base     = (r_fwd_valid && (r_fwd_addr == r_s1_addr)) ? r_fwd_data : w_rd_data;
    assign w_upd_new  = CNT_SIZE'(sat_inc(64'(w_base), c_cnt_max));
    assign w_qry_data = (r_fwd_valid && (r_fwd_addr == r_q1_addr)) ? r_fwd_data : w_rd_data;

    assign w_wr_en    = (r_state == CLEAR) || r_s1_valid;
    assign w_wr_addr  = (r_state == CLEAR) ? r_clr_addr : r_s1_addr;
    assign w_wr_data  = (r_state == CLEAR) ? '0 : w_upd_new;

    cm_sketch_counter_ram #(
        .DEPTH  (W),
        .ADDR_W (HASH_SIZE),
        .DATA_W (CNT_SIZE)
    ) u_ram (
        .clk       (clk),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (w_wr_addr),
        .i_wr_data (w_wr_data),
        .i_rd_addr (w_rd_addr),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= CLEAR;
            r_clr_addr  <= '0;
            r_s1_valid  <= 1'b0;
            r_s1_addr   <= '0;
            r_q1_valid  <= 1'b0;
            r_q1_addr   <= '0;
            r_fwd_valid <= 1'b0;
            r_fwd_addr  <= '0;
            r_fwd_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (r_state == CLEAR) begin
                r_clr_addr <= (r_clr_addr == c_last_addr) ? '0 : r_clr_addr + HASH_SIZE'(1);
            end
            r_s1_valid  <= w_upd_fire;
            r_s1_addr   <= upd_hash;
            r_q1_valid  <= w_qry_fire;
            r_q1_addr   <= qry_hash;
            r_fwd_valid <= w_wr_en;
            r_fwd_addr  <= w_wr_addr;
            r_fwd_data  <= w_wr_data;
            r_rsp_valid <= r_q1_valid;
            if (r_q1_valid) begin
                r_rsp_count <= w_qry_data;
            end
        end
    end

    assign upd_ready = w_upd_ready;
    assign qry_ready = w_qry_ready;
    assign clr_busy  = w_clr_busy;
    assign rsp_valid = r_rsp_valid;
    assign rsp_count = r_rsp_count;

endmodule

`default_nettype wire

// File: tb/tb_cm_sketch_row_counter.sv
// ============================================================================
// Module      : tb_cm_sketch_row_counter
// Description : Self-checking bench for one sketch row, built with 4-bit
//               counters so saturation is reachable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cm_sketch_row_counter;

    localparam int W    = 4096;
    localparam int HW   = 12;
    localparam int CNT  = 4;
    localparam int MAXV = (1 << CNT) - 1;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           upd_valid = 1'b0;
    logic           upd_ready;
    logic [HW-1:0]  upd_hash = '0;
    logic           qry_valid = 1'b0;
    logic           qry_ready;
    logic [HW-1:0]  qry_hash = '0;
    logic           rsp_valid;
    logic [CNT-1:0] rsp_count;
    logic           clr_start = 1'b0;
    logic           clr_busy;

    cm_sketch_row_counter #(
        .W         (W),
        .HASH_SIZE (HW),
        .CNT_SIZE  (CNT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .upd_valid (upd_valid),
        .upd_ready (upd_ready),
        .upd_hash  (upd_hash),
        .qry_valid (qry_valid),
        .qry_ready (qry_ready),
        .qry_hash  (qry_hash),
        .rsp_valid (rsp_valid),
        .rsp_count (rsp_count),
        .clr_start (clr_start),
        .clr_busy  (clr_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          due;
        logic [63:0] val;
    } exp_t;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    int unsigned model [W];
    exp_t        exp_q [$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        foreach (model[i]) model[i] = 0;
    endtask

    // Called at a sample point; applies one cycle of stimulus and advances.
    task automatic tick(input logic uv, input logic [HW-1:0] uh,
                        input logic qv, input logic [HW-1:0] qh,
                        input logic cs, input logic in_run);
        exp_t e;
        upd_valid = uv;
        upd_hash  = uh;
        qry_valid = qv;
        qry_hash  = qh;
        clr_start = cs;
        #1;
        if (in_run) begin
            check("upd_ready", 64'(upd_ready), 64'd1);
            check("qry_ready", 64'(qry_ready), 64'(!uv));
            if (uv) begin
                if (model[uh] < MAXV) model[uh]++;
            end else if (qv) begin
                e.due = cyc + 2;
                e.val = 64'(model[qh]);
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
        if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            check("rsp_valid", 64'(rsp_valid), 64'd1);
            check("rsp_count", 64'(rsp_count), exp_q[0].val);
            void'(exp_q.pop_front());
        end else begin
            check("rsp_idle", 64'(rsp_valid), 64'd0);
        end
    endtask

    // Counts busy cycles from the current sample point; optional clr_start pulse inside.
    task automatic wait_clear(input int exp_len, input string tag, input int glitch_at);
        int   n;
        logic bad_ready;
        n = 0;
        bad_ready = 1'b0;
        while (clr_busy === 1'b1 && n < W + 20) begin
            if (upd_ready !== 1'b0 || qry_ready !== 1'b0) bad_ready = 1'b1;
            tick(1'b0, '0, 1'b0, '0, (n == glitch_at), 1'b0);
            n++;
        end
        check({tag, "_len"}, 64'(n), 64'(exp_len));
        check({tag, "_noready"}, 64'(bad_ready), 64'd0);
        model_clear();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          uv;
        logic          qv;
        logic [HW-1:0] uh;
        logic [HW-1:0] qh;

        model_clear();
        repeat (3) @(posedge clk);
        #1;
        check("rst_upd_ready", 64'(upd_ready), 64'd0);
        check("rst_qry_ready", 64'(qry_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_count", 64'(rsp_count), 64'd0);
        check("rst_clr_busy",  64'(clr_busy),  64'd1);
        rst = 1'b0;
        wait_clear(W, "init_clear", -1);

        // Cleared row reads zero.
        tick(1'b0, '0, 1'b1, 12'd123, 1'b0, 1'b1);
        repeat (2) tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Back-to-back hits on one bucket.
        repeat (3) tick(1'b1, 12'd7, 1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b1, 12'd7, 1'b0, 1'b1);
        repeat (2) tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Alternating buckets, then update immediately followed by query.
        for (int i = 0; i < 4; i++) tick(1'b1, (i % 2 == 0) ? 12'd5 : 12'd6, 1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b1, 12'd5, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b1, 12'd6, 1'b0, 1'b1);
        tick(1'b1, 12'd9, 1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b1, 12'd9, 1'b0, 1'b1);
        repeat (2) tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Saturation at the counter maximum.
        repeat (17) tick(1'b1, 12'd0, 1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b1, 12'd0, 1'b0, 1'b1);
        repeat (2) tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Random mix concentrated on a few buckets to hit forwarding paths.
        for (int i = 0; i < 400; i++) begin
            uv = 1'($urandom_range(0, 1));
            qv = 1'($urandom_range(0, 1));
            uh = ($urandom_range(0, 3) == 0) ? HW'($urandom_range(0, W - 1)) : HW'($urandom_range(0, 7));
            qh = ($urandom_range(0, 3) == 0) ? HW'($urandom_range(0, W - 1)) : HW'($urandom_range(0, 7));
            tick(uv, uh, qv, qh, 1'b0, 1'b1);
        end
        repeat (3) tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Clear with an update in flight; a second clr_start during CLEAR is ignored.
        tick(1'b1, 12'd3, 1'b0, '0, 1'b0, 1'b1);
        tick(1'b1, 12'd3, 1'b0, '0, 1'b1, 1'b1);
        wait_clear(W + 2, "clear_upd", 100);
        for (int i = 0; i < 4; i++) tick(1'b0, '0, 1'b1, (i == 3) ? 12'd7 : HW'(i * 3), 1'b0, 1'b1);
        repeat (2) tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Clear with a query in flight: its response still arrives.
        tick(1'b1, 12'd4, 1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b1, 12'd4, 1'b1, 1'b1);
        wait_clear(W + 2, "clear_qry", -1);
        tick(1'b0, '0, 1'b1, 12'd4, 1'b0, 1'b1);
        repeat (2) tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        // Reset while responses are in flight.
        repeat (2) tick(1'b1, 12'd2, 1'b0, '0, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b1, 12'd2, 1'b0, 1'b1);
        tick(1'b0, '0, 1'b1, 12'd2, 1'b0, 1'b1);
        upd_valid = 1'b0;
        qry_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_rsp_drop", 64'(rsp_valid), 64'd0);
        check("rst_mid_busy",     64'(clr_busy),  64'd1);
        check("rst_mid_upd_rdy",  64'(upd_ready), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        cyc++;
        check("rst_mid_no_pulse", 64'(rsp_valid), 64'd0);
        rst = 1'b0;
        wait_clear(W, "rst_clear", -1);
        tick(1'b0, '0, 1'b1, 12'd2, 1'b0, 1'b1);
        repeat (2) tick(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
